proto245a_sc: RTL and testbench

- Single-clock bridge between an FTDI FT245-style asynchronous parallel FIFO interface and two internal synchronous FIFOs.
- Host-to-device bytes are read from the FT chip (RD# strobes) into an RX FIFO; the user side pops them.
- User-side bytes pushed into a TX FIFO are written to the FT chip (WR# strobes).
- The FT strobe pulse widths and the recovery time are counted in ft_clk ticks.

---
 rtl/proto245a_sc.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_proto245a_sc.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proto245a_sc.sv
// FT245-style asynchronous FIFO bridge, single clock domain.
// Bytes offered by the FT chip are strobed in with ft_rdn and queued in an RX FIFO;
// bytes pushed by the user into a TX FIFO are strobed out with ft_wrn.
// Every FT transaction is followed by a turnaround gap so stale flags are never acted on.
module proto245a_sc #(
    parameter int unsigned DATA_W           = 8,
    parameter int unsigned TX_FIFO_SIZE     = 32,
    parameter int unsigned RX_FIFO_SIZE     = 32,
    parameter int unsigned READ_TICKS       = 4,
    parameter int unsigned WRITE_TICKS      = 4,
    parameter int unsigned TURNAROUND_TICKS = 8
) (
    input  logic                              ft_clk,
    input  logic                              ft_rst,
    // FT chip side
    input  logic                              ft_rxfn,
    input  logic                              ft_txen,
    input  logic [DATA_W-1:0]                 ft_din,
    output logic [DATA_W-1:0]                 ft_dout,
    output logic                              ft_oe,
    output logic                              ft_rdn,
    output logic                              ft_wrn,
    output logic                              ft_siwu,
    // RX FIFO user side
    input  logic                              rxfifo_rd,
    output logic [DATA_W-1:0]                 rxfifo_data,
    output logic                              rxfifo_valid,
    output logic [$clog2(RX_FIFO_SIZE+1)-1:0] rxfifo_load,
    output logic                              rxfifo_empty,
    // TX FIFO user side
    input  logic [DATA_W-1:0]                 txfifo_data,
    input  logic                              txfifo_wr,
    output logic [$clog2(TX_FIFO_SIZE+1)-1:0] txfifo_load,
    output logic                              txfifo_full
);

    localparam int unsigned RxAw     = $clog2(RX_FIFO_SIZE);
    localparam int unsigned RxCw     = $clog2(RX_FIFO_SIZE + 1);
    localparam int unsigned TxAw     = $clog2(TX_FIFO_SIZE);
    localparam int unsigned TxCw     = $clog2(TX_FIFO_SIZE + 1);
    localparam int unsigned MaxRw    = (READ_TICKS > WRITE_TICKS) ? READ_TICKS : WRITE_TICKS;
    localparam int unsigned MaxTicks = (MaxRw > TURNAROUND_TICKS) ? MaxRw : TURNAROUND_TICKS;
    localparam int unsigned CntW     = $clog2(MaxTicks + 1);

    localparam logic [CntW-1:0] ReadLast  = CntW'(READ_TICKS - 1);
    localparam logic [CntW-1:0] WriteLast = CntW'(WRITE_TICKS - 1);
    localparam logic [CntW-1:0] TurnLast  = CntW'(TURNAROUND_TICKS - 1);
    localparam logic [RxCw-1:0] RxFull    = RxCw'(RX_FIFO_SIZE);
    localparam logic [TxCw-1:0] TxFull    = TxCw'(TX_FIFO_SIZE);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrSetup,
        StWrite,
        StWrHold,
        StTurn
    } state_e;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              last_rd_q, last_rd_d;   // 1 = previous transaction was a read
    logic              tx_pop;
    logic              rd_done;

    logic              rxfn_meta_q, rxfn_s_q;
    logic              txen_meta_q, txen_s_q;
    logic              rd_ok, wr_ok;

    logic              rdn_q, wrn_q, oe_q;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] din_q;
    logic              rx_push_q;

    logic [DATA_W-1:0] rx_mem [RX_FIFO_SIZE];
    logic [RxAw-1:0]   rx_wr_ptr_q, rx_rd_ptr_q;
    logic [RxCw-1:0]   rx_count_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              rx_push, rx_pop;

    logic [DATA_W-1:0] tx_mem [TX_FIFO_SIZE];
    logic [TxAw-1:0]   tx_wr_ptr_q, tx_rd_ptr_q;
    logic [TxCw-1:0]   tx_count_q;
    logic              tx_push;

    // ------------------------------------------------------------------
    // Flag synchronisers (idle-high, so reset to 1)
    // ------------------------------------------------------------------
    // Two-flop synchronisation of the asynchronous FT status flags.
    always_ff @(posedge ft_clk or posedge ft_rst) begin
        if (ft_rst) begin
            rxfn_meta_q <= 1'b1;
            rxfn_s_q    <= 1'b1;
            txen_meta_q <= 1'b1;
            txen_s_q    <= 1'b1;
        end else begin
            rxfn_meta_q <= ft_rxfn;
            rxfn_s_q    <= rxfn_meta_q;
            txen_meta_q <= ft_txen;
            txen_s_q    <= txen_meta_q;
        end
    end

    assign rd_ok = !rxfn_s_q && (rx_count_q < RxFull);
    assign wr_ok = !txen_s_q && (tx_count_q != '0);

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    // State, tick counter and arbitration history.
    always_ff @(posedge ft_clk or posedge ft_rst) begin
        if (ft_rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            last_rd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_rd_q <= last_rd_d;
        end
    end

    // Next-state logic; when both directions are ready they alternate.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_rd_d = last_rd_q;
        tx_pop    = 1'b0;
        rd_done   = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (rd_ok && (!wr_ok || !last_rd_q)) begin
                    state_d   = StRead;
                    last_rd_d = 1'b1;
                end else if (wr_ok) begin
                    state_d   = StWrSetup;
                    last_rd_d = 1'b0;
                    tx_pop    = 1'b1;
                end
            end
            StRead: begin
                if (cnt_q == ReadLast) begin
                    state_d = StTurn;
                    cnt_d   = '0;
                    rd_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWrSetup: begin
                state_d = StWrite;
                cnt_d   = '0;
            end
            StWrite: begin
                if (cnt_q == WriteLast) begin
                    state_d = StWrHold;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWrHold: begin
                state_d = StTurn;
                cnt_d   = '0;
            end
            StTurn: begin
                if (cnt_q == TurnLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // FT outputs are registered from the next state so strobes are glitch-free.
    always_ff @(posedge ft_clk or posedge ft_rst) begin
        if (ft_rst) begin
            rdn_q     <= 1'b1;
            wrn_q     <= 1'b1;
            oe_q      <= 1'b0;
            dout_q    <= '0;
            din_q     <= '0;
            rx_push_q <= 1'b0;
        end else begin
            rdn_q     <= (state_d != StRead);
            wrn_q     <= (state_d != StWrite);
            oe_q      <= (state_d == StWrSetup) || (state_d == StWrite) ||
                         (state_d == StWrHold);
            if (tx_pop) begin
                dout_q <= tx_mem[tx_rd_ptr_q];
            end
            // Sampled on the last low clock; pushed as ft_rdn rises.
            if (rd_done) begin
                din_q <= ft_din;
            end
            rx_push_q <= rd_done;
        end
    end

    assign ft_rdn  = rdn_q;
    assign ft_wrn  = wrn_q;
    assign ft_oe   = oe_q;
    assign ft_dout = dout_q;
    assign ft_siwu = 1'b1;

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    assign rx_push = rx_push_q && (rx_count_q != RxFull);
    assign rx_pop  = rxfifo_rd && (rx_count_q != '0);

    // RX storage, no reset needed.
    always_ff @(posedge ft_clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr_q] <= din_q;
        end
    end

    // RX pointers, occupancy and registered read port.
    always_ff @(posedge ft_clk or posedge ft_rst) begin
        if (ft_rst) begin
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_count_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr_q <= rx_wr_ptr_q + RxAw'(1);
            end
            if (rx_pop) begin
                rx_rd_ptr_q <= rx_rd_ptr_q + RxAw'(1);
                rx_data_q   <= rx_mem[rx_rd_ptr_q];
            end
            rx_valid_q <= rx_pop;
            if (rx_push && !rx_pop) begin
                rx_count_q <= rx_count_q + RxCw'(1);
            end else if (!rx_push && rx_pop) begin
                rx_count_q <= rx_count_q - RxCw'(1);
            end
        end
    end

    assign rxfifo_data  = rx_data_q;
    assign rxfifo_valid = rx_valid_q;
    assign rxfifo_load  = rx_count_q;
    assign rxfifo_empty = (rx_count_q == '0);

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    assign tx_push = txfifo_wr && (tx_count_q != TxFull);

    // TX storage, no reset needed.
    always_ff @(posedge ft_clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr_q] <= txfifo_data;
        end
    end

    // TX pointers and occupancy; tx_pop only fires when the FIFO is non-empty.
    always_ff @(posedge ft_clk or posedge ft_rst) begin
        if (ft_rst) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_count_q  <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr_q <= tx_wr_ptr_q + TxAw'(1);
            end
            if (tx_pop) begin
                tx_rd_ptr_q <= tx_rd_ptr_q + TxAw'(1);
            end
            if (tx_push && !tx_pop) begin
                tx_count_q <= tx_count_q + TxCw'(1);
            end else if (!tx_push && tx_pop) begin
                tx_count_q <= tx_count_q - TxCw'(1);
            end
        end
    end

    assign txfifo_load = tx_count_q;
    assign txfifo_full = (tx_count_q == TxFull);

endmodule

// File: tb/tb_proto245a_sc.sv
// Bench for proto245a_sc: FT chip model, RX/TX scoreboards and protocol monitor.
module tb_proto245a_sc;

    localparam int DW  = 8;
    localparam int TXS = 32;
    localparam int RXS = 32;
    localparam int RT  = 4;
    localparam int WT  = 4;
    localparam int TT  = 8;

    logic                          ft_clk = 1'b0;
    logic                          ft_rst = 1'b1;
    logic                          ft_rxfn;
    logic                          ft_txen = 1'b1;
    logic [DW-1:0]                 ft_din;
    logic [DW-1:0]                 ft_dout;
    logic                          ft_oe, ft_rdn, ft_wrn, ft_siwu;
    logic                          rxfifo_rd = 1'b0;
    logic [DW-1:0]                 rxfifo_data;
    logic                          rxfifo_valid;
    logic [$clog2(RXS+1)-1:0]      rxfifo_load;
    logic                          rxfifo_empty;
    logic [DW-1:0]                 txfifo_data = '0;
    logic                          txfifo_wr = 1'b0;
    logic [$clog2(TXS+1)-1:0]      txfifo_load;
    logic                          txfifo_full;

    proto245a_sc #(
        .DATA_W(DW), .TX_FIFO_SIZE(TXS), .RX_FIFO_SIZE(RXS),
        .READ_TICKS(RT), .WRITE_TICKS(WT), .TURNAROUND_TICKS(TT)
    ) dut (
        .ft_clk(ft_clk), .ft_rst(ft_rst), .ft_rxfn(ft_rxfn), .ft_txen(ft_txen),
        .ft_din(ft_din), .ft_dout(ft_dout), .ft_oe(ft_oe), .ft_rdn(ft_rdn),
        .ft_wrn(ft_wrn), .ft_siwu(ft_siwu), .rxfifo_rd(rxfifo_rd),
        .rxfifo_data(rxfifo_data), .rxfifo_valid(rxfifo_valid),
        .rxfifo_load(rxfifo_load), .rxfifo_empty(rxfifo_empty),
        .txfifo_data(txfifo_data), .txfifo_wr(txfifo_wr),
        .txfifo_load(txfifo_load), .txfifo_full(txfifo_full)
    );

    always #5 ft_clk = ~ft_clk;

    // FT chip model: a byte source consumed one per completed ft_rdn pulse.
    logic [7:0] rx_src [0:63];
    int         rx_idx = 0;
    int         rx_len = 0;
    assign ft_rxfn = (rx_idx >= rx_len);
    assign ft_din  = rx_src[rx_idx[5:0]];

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];
    int         strobe_log[$];     // 0 = read, 1 = write
    int         n_rx = 0;
    int         n_wr = 0;
    bit         mon_en = 1'b1;

    logic prev_rdn = 1'b1, prev_wrn = 1'b1, prev_oe = 1'b0;
    int   rd_lo = 0, wr_lo = 0, gap = 0;
    bit   seen = 1'b0, oe_off = 1'b0;

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_data;
        int         exp_load;
    } rx_vec_t;
    rx_vec_t vecs [4];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ft_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic add_rx(input logic [7:0] b);
        rx_src[rx_len[5:0]] = b;
        rx_len++;
    endtask

    // One push per clock; the first n_accept words are expected on the FT side.
    task automatic push_burst(input int base, input int n, input int n_accept);
        for (int i = 0; i < n; i++) begin
            tick();
            txfifo_wr   = 1'b1;
            txfifo_data = 8'(base + i);
            if (i < n_accept) tx_exp.push_back(8'(base + i));
        end
        tick();
        txfifo_wr = 1'b0;
    endtask

    task automatic wait_rx_load(input int target, input int budget, input string name);
        int k = 0;
        while (int'(rxfifo_load) != target && k < budget) begin
            @(negedge ft_clk);
            k++;
        end
        check(name, int'(rxfifo_load), target);
    endtask

    task automatic wait_tx_drained(input int budget, input string name);
        int k = 0;
        while ((tx_exp.size() != 0 || txfifo_load != 0) && k < budget) begin
            @(negedge ft_clk);
            k++;
        end
        check(name, tx_exp.size(), 0);
    endtask

    task automatic drain_rx(input int count, input int budget, input string name);
        int got = n_rx;
        int k = 0;
        tick();
        rxfifo_rd = 1'b1;
        while (n_rx - got < count && k < budget) begin
            @(negedge ft_clk);
            k++;
        end
        tick();
        rxfifo_rd = 1'b0;
        check(name, n_rx - got, count);
    endtask

    // Protocol monitor and scoreboard sampling on the falling edge.
    task automatic monitor();
        int exp_b;
        forever begin
            @(negedge ft_clk);
            if (!ft_rdn || !ft_wrn) begin
                check("strobe_overlap", int'(!ft_rdn && !ft_wrn), 0);
                if (!ft_rdn) check("oe_during_read", int'(ft_oe), 0);
            end
            if ((!ft_rdn && prev_rdn) || (!ft_wrn && prev_wrn)) begin
                if (mon_en && seen) check("strobe_gap_ge_turnaround", int'(gap >= TT), 1);
                if (!ft_wrn && prev_wrn) check("oe_in_wr_setup", int'(prev_oe), 1);
                seen = 1'b1;
                gap  = 0;
            end else if (ft_rdn && ft_wrn) begin
                gap++;
            end
            if (!ft_rdn) begin
                rd_lo++;
            end else if (!prev_rdn) begin
                if (mon_en && rx_idx < rx_len) begin
                    check("rdn_low_clocks", rd_lo, RT);
                    rx_exp.push_back(rx_src[rx_idx[5:0]]);
                    strobe_log.push_back(0);
                end
                if (rx_idx < rx_len) rx_idx++;
                rd_lo = 0;
            end
            if (!ft_wrn) begin
                wr_lo++;
            end else if (!prev_wrn) begin
                check("wrn_low_clocks", wr_lo, WT);
                check("oe_in_wr_hold", int'(ft_oe), 1);
                exp_b = (tx_exp.size() != 0) ? int'(tx_exp.pop_front()) : -1;
                check("tx_byte", int'(ft_dout), exp_b);
                n_wr++;
                strobe_log.push_back(1);
                wr_lo  = 0;
                oe_off = 1'b1;
            end else if (oe_off) begin
                check("oe_after_wr_hold", int'(ft_oe), 0);
                oe_off = 1'b0;
            end
            if (rxfifo_valid) begin
                exp_b = (rx_exp.size() != 0) ? int'(rx_exp.pop_front()) : -1;
                check("rx_byte", int'(rxfifo_data), exp_b);
                n_rx++;
            end
            prev_rdn = ft_rdn;
            prev_wrn = ft_wrn;
            prev_oe  = ft_oe;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int wr0;
        int k;
        vecs[0] = '{din: 8'hA5, exp_data: 8'hA5, exp_load: 1};
        vecs[1] = '{din: 8'h00, exp_data: 8'h00, exp_load: 1};
        vecs[2] = '{din: 8'hFF, exp_data: 8'hFF, exp_load: 1};
        vecs[3] = '{din: 8'h5A, exp_data: 8'h5A, exp_load: 1};

        fork
            monitor();
        join_none

        // Reset values
        @(negedge ft_clk);
        check("rst_rdn", int'(ft_rdn), 1);
        check("rst_wrn", int'(ft_wrn), 1);
        check("rst_oe", int'(ft_oe), 0);
        check("rst_dout", int'(ft_dout), 0);
        check("rst_siwu", int'(ft_siwu), 1);
        check("rst_rx_valid", int'(rxfifo_valid), 0);
        check("rst_rx_data", int'(rxfifo_data), 0);
        check("rst_rx_empty", int'(rxfifo_empty), 1);
        check("rst_rx_load", int'(rxfifo_load), 0);
        check("rst_tx_full", int'(txfifo_full), 0);
        check("rst_tx_load", int'(txfifo_load), 0);
        tick();
        ft_rst = 1'b0;

        // Asynchronous reset in the middle of a read discards the byte
        mon_en = 1'b0;
        tick();
        add_rx(8'h3C);
        k = 0;
        while (ft_rdn && k < 50) begin
            @(negedge ft_clk);
            k++;
        end
        check("midread_rdn_low", int'(ft_rdn), 0);
        @(posedge ft_clk);
        #3 ft_rst = 1'b1;
        #1;
        check("midread_rst_rdn", int'(ft_rdn), 1);
        check("midread_rst_empty", int'(rxfifo_empty), 1);
        check("midread_rst_rx_load", int'(rxfifo_load), 0);
        check("midread_rst_tx_load", int'(txfifo_load), 0);
        check("midread_rst_siwu", int'(ft_siwu), 1);
        tick();
        ft_rst = 1'b0;
        idle(20);
        check("midread_byte_discarded", int'(rxfifo_load), 0);
        mon_en = 1'b1;

        // Single-byte reads, table-driven
        for (int i = 0; i < 4; i++) begin
            tick();
            add_rx(vecs[i].din);
            wait_rx_load(vecs[i].exp_load, 200, "rx_single_load");
            tick();
            rxfifo_rd = 1'b1;
            tick();
            rxfifo_rd = 1'b0;
            @(negedge ft_clk);
            check("rx_single_valid", int'(rxfifo_valid), 1);
            check("rx_single_data", int'(rxfifo_data), int'(vecs[i].exp_data));
            tick();
            rxfifo_rd = 1'b1;
            tick();
            rxfifo_rd = 1'b0;
            @(negedge ft_clk);
            check("rx_pop_empty_valid", int'(rxfifo_valid), 0);
            check("rx_pop_empty_flag", int'(rxfifo_empty), 1);
        end

        // RX backpressure: 40 bytes offered, nobody reads
        tick();
        base = rx_idx;
        for (int i = 0; i < 40; i++) add_rx(8'(i));
        wait_rx_load(RXS, 1500, "rx_bp_load_full");
        idle(60);
        check("rx_bp_load_held", int'(rxfifo_load), RXS);
        check("rx_bp_rdn_idle", int'(ft_rdn), 1);
        check("rx_bp_reads_stopped", rx_idx - base, RXS);
        drain_rx(40, 2000, "rx_bp_drained_count");
        idle(3);
        check("rx_bp_load_zero", int'(rxfifo_load), 0);
        check("rx_bp_scoreboard_empty", rx_exp.size(), 0);

        // TX burst
        idle(2);
        ft_txen = 1'b0;
        wr0 = n_wr;
        push_burst(8'h00, 32, 32);
        wait_tx_drained(2000, "tx_burst_drained");
        check("tx_burst_count", n_wr - wr0, 32);
        check("tx_burst_load", int'(txfifo_load), 0);

        // TX stall with the FT chip refusing data
        ft_txen = 1'b1;
        idle(15);
        wr0 = n_wr;
        push_burst(8'h40, 33, 32);
        @(negedge ft_clk);
        check("tx_stall_full", int'(txfifo_full), 1);
        check("tx_stall_load", int'(txfifo_load), TXS);
        idle(30);
        check("tx_stall_no_writes", n_wr - wr0, 0);
        check("tx_stall_wrn_idle", int'(ft_wrn), 1);
        ft_txen = 1'b0;
        wait_tx_drained(2000, "tx_stall_drained");
        check("tx_stall_count", n_wr - wr0, 32);

        // Bidirectional after reset: read first, then alternate
        ft_txen = 1'b1;
        idle(15);
        @(posedge ft_clk);
        #3 ft_rst = 1'b1;
        idle(2);
        ft_rst = 1'b0;
        push_burst(8'h80, 4, 4);
        strobe_log.delete();
        tick();
        for (int i = 0; i < 4; i++) add_rx(8'(8'hC0 + i));
        ft_txen = 1'b0;
        k = 0;
        while ((int'(rxfifo_load) != 4 || tx_exp.size() != 0) && k < 1000) begin
            @(negedge ft_clk);
            k++;
        end
        idle(12);
        check("bidir_strobe_count", strobe_log.size(), 8);
        for (int i = 0; i < 8 && i < strobe_log.size(); i++) begin
            check("bidir_alternation", strobe_log[i], i % 2);
        end
        drain_rx(4, 200, "bidir_rx_count");
        idle(3);
        check("bidir_rx_scoreboard_empty", rx_exp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
